gate_unit_arbiter: RTL and testbench
====================================

Name: gate_unit_arbiter

Overview:
- Shares one W-bit Hack-style logic unit between two requesters.
- The unit performs NOT, AND, OR and MUX, built from the team's existing elementary gates.
- Round-robin arbitration, valid/ready handshakes on both request ports and the response port, registered operands and result.
- Sits between the two gate-level clients and the single logic datapath, so only one copy of the gates is instantiated.

Parameters:
- WIDTH, 8, operand/result width in bits.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  2  0=NOT a, 1=a AND b, 2=a OR b, 3=MUX(sel ? b : a).
- req0_a  input  WIDTH  operand a.
- req0_b  input  WIDTH  operand b.
- req0_sel  input  1  mux select.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_sel: same as the requester 0 ports, for requester 1.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_data  output  WIDTH  operation result.
- resp_id  output  1  requester that issued the result.
- busy  output  1  high when not in IDLE.
- ops_done  output  CNT_W  completed-response count, wraps.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE.
  - req0_ready=req1_ready=0, resp_valid=0, resp_data=0, resp_id=0, busy=0, ops_done=0.
  - Priority pointer set so requester 0 wins first.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - reqN_ready is combinational and high only in IDLE, only for the winner.
  - Winner: the single valid requester; if both are valid, the one the pointer favours.
  - On the clock edge where reqN_valid && reqN_ready: capture op/a/b/sel/id into registers; set pointer to favour the other requester; go to EXEC.
  - No valid requester: stay in IDLE.
- EXEC:
  - Logic unit evaluates the registered operands.
  - Result registered into resp_data; resp_id gets the captured id; resp_valid=1; go to DONE.
- DONE:
  - Hold resp_valid, resp_data and resp_id stable.
  - On the edge with resp_ready=1: resp_valid to 0, ops_done+1 (wraps 2^CNT_W-1 to 0), go to IDLE.
  - Both reqN_ready stay 0 in EXEC and DONE.
- Latency and throughput:
  - Accept edge N; resp_valid high after edge N+1.
  - Earliest next accept is the edge after the response handshake, so at most one operation per 3 cycles.
- Datapath:
  - Bitwise across WIDTH; no carries, no width growth.
  - For NOT, b and sel are ignored.
  - The MUX select is per-word, not per-bit.
- Requester rule: a requester keeps valid and its operands stable until ready. The arbiter does not check this; anything changed before acceptance is simply sampled at acceptance.
- Boundary conditions:
  - Simultaneous valid: pointer decides. The loser is served on the next IDLE if still valid.
  - A requester dropping valid while waiting is not an error; nothing is captured.
  - resp_ready held high in DONE: the response completes in a single cycle.
  - resp_ready high outside DONE has no effect.
  - rst_n low at any time, including in EXEC or DONE: the in-flight operation is discarded with no response, all outputs return to reset values immediately, and the counter clears.

Test Plan:
- Reset, then req0 NOT with a=78 -> req0_ready=1 for one cycle; 2 cycles later resp_valid=1, resp_data=177, resp_id=0; with resp_ready=1, ops_done=1.
- req1 AND with a=150, b=2, then req1 OR with a=150, b=2 -> resp_data=2 then 150, resp_id=1; second accept no earlier than 3 cycles after the first.
- req0 MUX with a=200, b=1: sel=1 -> 1, sel=0 -> 200.
- Both valid right after reset, held -> grant order 0,1,0,1; resp_id alternates; no starvation over 8 operations.
- resp_ready low for 5 cycles in DONE -> resp_data/resp_id stable, both ready outputs 0, busy=1; then resp_ready=1 -> IDLE next cycle.
- rst_n asserted in EXEC -> no resp_valid and immediate reset values.
- 256 completed operations -> ops_done wraps to 0.

Source files
------------

// File: rtl/gate_unit_arbiter.sv
// Purpose: shares one WIDTH-bit NOT/AND/OR/MUX logic unit between two
//          requesters with round-robin arbitration and registered operands/result.
// Latency: accept on edge N, resp_valid high after edge N+1; at most one op per 3 cycles.
// Backpressure: resp_valid/data/id held in DONE until resp_ready; no requester is
//          accepted until the response handshake completes.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   reqN_valid/reqN_ready           request handshake, requester N (0/1)
//   reqN_op/reqN_a/reqN_b/reqN_sel  0=NOT a, 1=a&b, 2=a|b, 3=sel?b:a
//   resp_valid/resp_ready           response handshake
//   resp_data/resp_id               result and issuing requester
//   busy                            high when not IDLE
//   ops_done                        completed-response counter (wraps)
module gate_unit_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sel,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ptr;        // 1: requester 1 wins a tie
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sel;
  logic             r_id;
  logic [WIDTH-1:0] r_resp_data;
  logic             r_resp_id;
  logic             r_resp_valid;
  logic [CNT_W-1:0] r_ops_done;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic [WIDTH-1:0] w_not;
  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_mux;
  logic [WIDTH-1:0] w_selmask;
  logic [WIDTH-1:0] w_result;

  // Next-state and grant logic. Grants exist only in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant0 = req0_valid && (!req1_valid || !r_ptr);
        w_grant1 = req1_valid && !w_grant0;
        if (w_grant0 || w_grant1) begin
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_state_nxt = DONE;
      end
      DONE: begin
        if (resp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // A grant equals acceptance: the winner is by definition valid.
  assign w_accept = w_grant0 || w_grant1;

  // Shared logic unit. MUX is composed from the same AND/OR/NOT gates,
  // with the per-word select replicated across the word.
  assign w_selmask = {WIDTH{r_sel}};
  assign w_not     = ~r_a;
  assign w_and     = r_a & r_b;
  assign w_or      = r_a | r_b;
  assign w_mux     = (r_a & ~w_selmask) | (r_b & w_selmask);

  always_comb begin
    w_result = w_not;
    case (r_op)
      2'd0:    w_result = w_not;
      2'd1:    w_result = w_and;
      2'd2:    w_result = w_or;
      default: w_result = w_mux;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= 1'b0;
      r_op         <= 2'd0;
      r_a          <= '0;
      r_b          <= '0;
      r_sel        <= 1'b0;
      r_id         <= 1'b0;
      r_resp_data  <= '0;
      r_resp_id    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_ops_done   <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= w_grant1 ? req1_op  : req0_op;
        r_a   <= w_grant1 ? req1_a   : req0_a;
        r_b   <= w_grant1 ? req1_b   : req0_b;
        r_sel <= w_grant1 ? req1_sel : req0_sel;
        r_id  <= w_grant1;
        // Hand priority to the requester that was not just served.
        r_ptr <= !w_grant1;
      end
      if (r_state == EXEC) begin
        r_resp_data  <= w_result;
        r_resp_id    <= r_id;
        r_resp_valid <= 1'b1;
      end
      if ((r_state == DONE) && resp_ready) begin
        r_resp_valid <= 1'b0;
        r_ops_done   <= r_ops_done + CNT_W'(1);
      end
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_id    = r_resp_id;
  assign busy       = (r_state != IDLE);
  assign ops_done   = r_ops_done;

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Purpose: self-checking bench for gate_unit_arbiter: directed scenarios plus
//          randomized traffic checked every cycle against a transaction-level model.
// Latency/backpressure: inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
module tb_gate_unit_arbiter;

  localparam int W = 8;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_sel = 1'b0, req1_sel = 1'b0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [W-1:0] resp_data;
  logic         resp_id;
  logic         busy;
  logic [C-1:0] ops_done;

  gate_unit_arbiter #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id),
    .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Operation semantics straight from the op table.
  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic sel);
    case (op)
      2'd0:    return ~a;
      2'd1:    return a & b;
      2'd2:    return a | b;
      default: return sel ? b : a;
    endcase
  endfunction

  // Transaction-level model: where the single in-flight operation is
  // (0 none, 1 computing, 2 result presented), which requester wins a tie,
  // the expected result and the number of completed responses.
  int           m_where = 0;
  int           m_fav   = 0;
  int           m_done  = 0;
  logic [W-1:0] m_data  = '0;
  logic         m_id    = 1'b0;

  always @(negedge clk) begin
    logic e0, e1;
    if (!rst_n) begin
      m_where = 0; m_fav = 0; m_done = 0;
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ops_done", ops_done, 0);
    end else begin
      e0 = (m_where == 0) && req0_valid && (!req1_valid || m_fav == 0);
      e1 = (m_where == 0) && req1_valid && !e0;
      chk("m_req0_ready", req0_ready, e0);
      chk("m_req1_ready", req1_ready, e1);
      chk("m_busy", busy, m_where != 0);
      chk("m_resp_valid", resp_valid, m_where == 2);
      chk("m_ops_done", ops_done, m_done % 256);
      if (m_where == 2) begin
        chk("m_resp_data", resp_data, m_data);
        chk("m_resp_id", resp_id, m_id);
      end
      if (m_where == 0 && (e0 || e1)) begin
        m_id    = e1;
        m_data  = e1 ? ref_op(req1_op, req1_a, req1_b, req1_sel)
                     : ref_op(req0_op, req0_a, req0_b, req0_sel);
        m_fav   = e1 ? 0 : 1;
        m_where = 1;
      end else if (m_where == 1) begin
        m_where = 2;
      end else if (m_where == 2 && resp_ready) begin
        m_done++;
        m_where = 0;
      end
    end
  end

  task automatic set_req(input int id, input logic v, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic sel);
    if (id == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_sel = sel;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_sel = sel;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One operation with resp_ready high; checks result against a constant
  // and returns the cycle of acceptance. Starts and ends 1 ns after an edge.
  task automatic issue(input string tag, input int id, input logic [1:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic sel,
                       input logic [W-1:0] exp, output int acc_cyc);
    bit got;
    got = 0;
    acc_cyc = -1;
    resp_ready = 1'b1;
    set_req(id, 1'b1, op, a, b, sel);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) got = 1;
    end
    if (!got) begin
      chk({tag, "_accept_timeout"}, 0, 1);
      set_req(id, 1'b0, 2'd0, '0, '0, 1'b0);
      return;
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    set_req(id, 1'b0, 2'd0, '0, '0, 1'b0);
    @(negedge clk);
    chk({tag, "_exec_valid"}, resp_valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, resp_valid, 1);
    chk({tag, "_data"}, resp_data, exp);
    chk({tag, "_id"}, resp_id, id);
    @(posedge clk); #1;
  endtask

  initial begin
    int t0, t1;
    int exp_id;
    bit got;
    bit a0, a1;
    logic [1:0] op;
    logic [W-1:0] a, b;
    logic sel;

    do_reset();

    // NOT 78 -> 177, then counter
    issue("not78", 0, 2'd0, 8'd78, 8'd0, 1'b0, 8'd177, t0);
    @(negedge clk);
    chk("not78_ops_done", ops_done, 1);
    chk("not78_idle", busy, 0);
    @(posedge clk); #1;

    // AND / OR back to back from requester 1
    issue("and", 1, 2'd1, 8'd150, 8'd2, 1'b0, 8'd2, t0);
    issue("or", 1, 2'd2, 8'd150, 8'd2, 1'b0, 8'd150, t1);
    chk("or_gap_ge3", (t1 - t0) >= 3, 1);

    // MUX word select
    issue("mux_sel1", 0, 2'd3, 8'd200, 8'd1, 1'b1, 8'd1, t0);
    issue("mux_sel0", 0, 2'd3, 8'd200, 8'd1, 1'b0, 8'd200, t0);

    // Both held valid from reset: strict alternation starting with 0
    do_reset();
    resp_ready = 1'b1;
    set_req(0, 1'b1, 2'd2, 8'h0F, 8'h00, 1'b0);
    set_req(1, 1'b1, 2'd2, 8'hF0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (resp_valid) got = 1;
      end
      exp_id = i % 2;
      chk("rr_timeout", got, 1);
      chk("rr_id", resp_id, exp_id);
      chk("rr_data", resp_data, (exp_id == 0) ? 8'h0F : 8'hF0);
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 2'd0, '0, '0, 1'b0);
    set_req(1, 1'b0, 2'd0, '0, '0, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // Stall in DONE for 5 cycles with the other requester waiting
    resp_ready = 1'b0;
    set_req(1, 1'b1, 2'd0, 8'h55, 8'h00, 1'b0);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req1_ready) got = 1;
    end
    chk("stall_accept", got, 1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 2'd0, '0, '0, 1'b0);
    set_req(0, 1'b1, 2'd1, 8'hFF, 8'h3C, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", resp_valid, 1);
      chk("stall_data", resp_data, 8'hAA);
      chk("stall_id", resp_id, 1);
      chk("stall_rdy0", req0_ready, 0);
      chk("stall_rdy1", req1_ready, 0);
      chk("stall_busy", busy, 1);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    set_req(0, 1'b0, 2'd0, '0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("stall_release_idle", busy, 0);
    chk("stall_release_valid", resp_valid, 0);

    // Reset while EXEC: nothing comes out
    @(posedge clk); #1;
    set_req(0, 1'b1, 2'd0, 8'h12, 8'h00, 1'b0);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req0_ready) got = 1;
    end
    chk("rexec_accept", got, 1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 2'd0, '0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rexec_busy", busy, 0);
    chk("rexec_valid", resp_valid, 0);
    chk("rexec_ops", ops_done, 0);
    chk("rexec_data", resp_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rexec_no_resp", resp_valid, 0);
    end
    @(posedge clk); #1;

    // 256 random operations: counter wraps to 0
    for (int i = 0; i < 256; i++) begin
      op = 2'($urandom_range(0, 3));
      a = 8'($urandom); b = 8'($urandom); sel = 1'($urandom);
      issue("wrap_op", $urandom_range(0, 1), op, a, b, sel, ref_op(op, a, b, sel), t0);
    end
    @(negedge clk);
    chk("wrap_ops_done", ops_done, 0);
    @(posedge clk); #1;

    // Random traffic, checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (a0 || !req0_valid)
        set_req(0, ($urandom % 3) == 0, 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      else if (($urandom % 20) == 0)
        req0_valid = 1'b0;
      if (a1 || !req1_valid)
        set_req(1, ($urandom % 3) == 0, 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      else if (($urandom % 20) == 0)
        req1_valid = 1'b0;
      resp_ready = 1'($urandom);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
